// File: rtl/bus_datapath.sv
// Purpose : single-bus CPU datapath (GPRs, HI/LO, PC, IR, MAR, MDR, Y, 2xWIDTH Z) with ALU and iterative MUL/DIV.
// Latency : bus is combinational, register loads take 1 edge, MUL/DIV Z valid WIDTH+1 edges after operand capture.
// Backpress: alu_busy marks a running MUL/DIV; Z writes requested while it runs are dropped, other transfers continue.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high clear
//   reg_in / reg_out    per-GPR write enable / bus drive select
//   src_out             bus select: 0 HI, 1 LO, 2 ZHI, 3 ZLO, 4 PC, 5 MDR, 6 INPORT, 7 CSIGN
//   ctl_in              write enable: 0 HI, 1 LO, 2 PC, 3 MDR, 4 Y, 5 Z, 6 MAR, 7 IR
//   alu_op              ALU operation (A = Y, B = bus)
//   md_read             MDR source: 1 = mdata_in, 0 = bus
//   mdata_in, inport_in, csign_in   external bus sources
//   bus_out, pc_q, ir_q, mar_q      observed values
//   alu_busy, alu_done              MUL/DIV handshake
//   sel_err             sticky flag: more than one bus driver was selected
//
// Build option: define R0_ZERO_EN to hard-wire R0 to zero (reads 0, writes discarded, no flop).
module bus_datapath #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] reg_in,
    input  logic [NUM_REGS-1:0] reg_out,
    input  logic [7:0]          src_out,
    input  logic [7:0]          ctl_in,
    input  logic [3:0]          alu_op,
    input  logic                md_read,
    input  logic [WIDTH-1:0]    mdata_in,
    input  logic [WIDTH-1:0]    inport_in,
    input  logic [WIDTH-1:0]    csign_in,
    output logic [WIDTH-1:0]    bus_out,
    output logic [WIDTH-1:0]    pc_q,
    output logic [WIDTH-1:0]    ir_q,
    output logic [WIDTH-1:0]    mar_q,
    output logic                alu_busy,
    output logic                alu_done,
    output logic                sel_err
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_NEG  = 4'd9;
    localparam logic [3:0] OP_NOT  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   reg_q [NUM_REGS];
    logic [WIDTH-1:0]   hi_q, lo_q, pc_r, ir_r, mar_r, mdr_q, y_q;
    logic [2*WIDTH-1:0] z_q;
    logic               sel_err_q;

    // ------------------------------------------------------------------
    // General register file
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
`ifdef R0_ZERO_EN
        if (gi == 0) begin : g_zero
            assign reg_q[gi] = '0;
        end else begin : g_ff
            always_ff @(posedge clk) begin
                if (reset)           reg_q[gi] <= '0;
                else if (reg_in[gi]) reg_q[gi] <= bus_out;
            end
        end
`else
        always_ff @(posedge clk) begin
            if (reset)           reg_q[gi] <= '0;
            else if (reg_in[gi]) reg_q[gi] <= bus_out;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Bus: later assignments win, so scanning from the highest index down
    // leaves the lowest selected GPR (then lowest src_out bit) on the bus.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] src_val [8];

    always_comb begin
        src_val[0] = hi_q;
        src_val[1] = lo_q;
        src_val[2] = z_q[2*WIDTH-1:WIDTH];
        src_val[3] = z_q[WIDTH-1:0];
        src_val[4] = pc_r;
        src_val[5] = mdr_q;
        src_val[6] = inport_in;
        src_val[7] = csign_in;
    end

    always_comb begin
        bus_out = '0;
        for (int i = 7; i >= 0; i--) begin
            if (src_out[i]) bus_out = src_val[i];
        end
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (reg_out[i]) bus_out = reg_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Special registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pc_r      <= '0;
            ir_r      <= '0;
            mar_r     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            sel_err_q <= 1'b0;
        end else begin
            if (ctl_in[0]) hi_q  <= bus_out;
            if (ctl_in[1]) lo_q  <= bus_out;
            if (ctl_in[2]) pc_r  <= bus_out;
            if (ctl_in[3]) mdr_q <= md_read ? mdata_in : bus_out;
            if (ctl_in[4]) y_q   <= bus_out;
            if (ctl_in[6]) mar_r <= bus_out;
            if (ctl_in[7]) ir_r  <= bus_out;
            if ($countones({reg_out, src_out}) > 1) sel_err_q <= 1'b1;
        end
    end

    assign pc_q    = pc_r;
    assign ir_q    = ir_r;
    assign mar_q   = mar_r;
    assign sel_err = sel_err_q;

    // ------------------------------------------------------------------
    // Single-cycle ALU (A = Y, B = bus)
    // ------------------------------------------------------------------
    logic [SW-1:0]      amt;
    logic [2*WIDTH-1:0] rot_src, rot_r, rot_l;
    logic [WIDTH-1:0]   alu_res;

    assign amt     = bus_out[SW-1:0];
    assign rot_src = {y_q, y_q};
    assign rot_r   = rot_src >> amt;
    assign rot_l   = rot_src << amt;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = y_q + bus_out;
            OP_SUB:  alu_res = y_q - bus_out;
            OP_AND:  alu_res = y_q & bus_out;
            OP_OR:   alu_res = y_q | bus_out;
            OP_SHR:  alu_res = y_q >> amt;
            OP_SHRA: alu_res = $signed(y_q) >>> amt;
            OP_SHL:  alu_res = y_q << amt;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_res = -bus_out;
            OP_NOT:  alu_res = ~bus_out;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative MUL/DIV on operand magnitudes; signs are applied at the end.
    //   MUL: md_opa = shifting multiplicand, md_opb = shifting multiplier,
    //        md_acc = running product.
    //   DIV: md_opa = divisor, md_opb = dividend bits out / quotient bits in,
    //        md_acc[WIDTH-1:0] = partial remainder.
    // ------------------------------------------------------------------
    md_state_t          md_state, md_next;
    logic [SW-1:0]      md_cnt;
    logic               md_is_div, md_neg_q, md_neg_r, md_dvz;
    logic [2*WIDTH-1:0] md_opa, md_acc;
    logic [WIDTH-1:0]   md_opb, md_dividend;
    logic               md_op_sel, md_start;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_bit;
    logic [2*WIDTH-1:0] mul_res, div_res;
    logic [WIDTH-1:0]   quo_res, rem_res;

    assign md_op_sel = (alu_op == OP_MUL) || (alu_op == OP_DIV);
    assign md_start  = (md_state == MD_IDLE) && ctl_in[5] && md_op_sel;

    assign a_mag = y_q[WIDTH-1]     ? -y_q     : y_q;
    assign b_mag = bus_out[WIDTH-1] ? -bus_out : bus_out;

    // Remainder stays below the divisor (at most 2^(WIDTH-1)), so the trial
    // value never overflows WIDTH bits; div_diff[WIDTH] is the borrow.
    assign div_trial = {md_acc[WIDTH-1:0], md_opb[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, md_opa[WIDTH-1:0]};
    assign div_bit   = ~div_diff[WIDTH];

    assign mul_res = md_neg_q ? -md_acc : md_acc;
    assign quo_res = md_neg_q ? -md_opb : md_opb;
    assign rem_res = md_neg_r ? -md_acc[WIDTH-1:0] : md_acc[WIDTH-1:0];
    assign div_res = md_dvz ? {md_dividend, {WIDTH{1'b1}}} : {rem_res, quo_res};

    always_ff @(posedge clk) begin
        if (reset) md_state <= MD_IDLE;
        else       md_state <= md_next;
    end

    always_comb begin
        md_next  = md_state;
        alu_busy = 1'b0;
        alu_done = 1'b0;
        case (md_state)
            MD_IDLE: if (md_start) md_next = MD_RUN;
            MD_RUN: begin
                alu_busy = 1'b1;
                if (md_cnt == SW'(WIDTH - 1)) md_next = MD_DONE;
            end
            MD_DONE: begin
                alu_done = 1'b1;
                md_next  = MD_IDLE;
            end
            default: md_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt      <= '0;
            md_is_div   <= 1'b0;
            md_neg_q    <= 1'b0;
            md_neg_r    <= 1'b0;
            md_dvz      <= 1'b0;
            md_opa      <= '0;
            md_opb      <= '0;
            md_acc      <= '0;
            md_dividend <= '0;
        end else if (md_start) begin
            md_cnt      <= '0;
            md_is_div   <= (alu_op == OP_DIV);
            md_neg_q    <= y_q[WIDTH-1] ^ bus_out[WIDTH-1];
            md_neg_r    <= y_q[WIDTH-1];
            md_dvz      <= (bus_out == '0);
            md_dividend <= y_q;
            md_acc      <= '0;
            if (alu_op == OP_DIV) begin
                md_opa <= {{WIDTH{1'b0}}, b_mag};
                md_opb <= a_mag;
            end else begin
                md_opa <= {{WIDTH{1'b0}}, a_mag};
                md_opb <= b_mag;
            end
        end else if (md_state == MD_RUN) begin
            md_cnt <= md_cnt + 1'b1;
            if (md_is_div) begin
                md_acc[WIDTH-1:0] <= div_bit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
                md_opb            <= {md_opb[WIDTH-2:0], div_bit};
            end else begin
                if (md_opb[0]) md_acc <= md_acc + md_opa;
                md_opa <= md_opa << 1;
                md_opb <= md_opb >> 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Z: MUL/DIV result lands at the end of DONE; single-cycle ops only
    // load while the iterative unit is idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= '0;
        end else if (md_state == MD_DONE) begin
            z_q <= md_is_div ? div_res : mul_res;
        end else if ((md_state == MD_IDLE) && ctl_in[5] && !md_op_sel) begin
            z_q <= {{WIDTH{1'b0}}, alu_res};
        end
    end

endmodule

// File: doc/bus_datapath.md
Name: bus_datapath

Overview:
- Parametrised single-bus CPU datapath: general register file, HI/LO, PC, IR, MAR, MDR, Y and 2×WIDTH Z, all sharing one bus.
- Bus source is chosen from one-hot out-selects. Detection of illegal multi-select is registered.
- The ALU takes A=Y and B=bus. Multiply and divide run as multi-cycle iterative operations with a busy/done handshake.
- Sits under the CPU top as the generalised successor of the fixed 32-bit, 16-register datapath; the control unit drives all select/enable lines.

Parameters:
- WIDTH, 32, datapath word width (≥8, power of 2).
- NUM_REGS, 16, number of general registers R0..R(NUM_REGS-1) (2..32).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high clear.
- reg_in  in  NUM_REGS  per-register write enable.
- reg_out  in  NUM_REGS  per-register bus drive select.
- src_out  in  8  bus select; bit0 HI, 1 LO, 2 ZHI, 3 ZLO, 4 PC, 5 MDR, 6 INPORT, 7 CSIGN.
- ctl_in  in  8  write enable; bit0 HI, 1 LO, 2 PC, 3 MDR, 4 Y, 5 Z, 6 MAR, 7 IR.
- alu_op  in  4  ALU operation code.
- md_read  in  1  MDR input mux: 1 = mdata_in, 0 = bus.
- mdata_in  in  WIDTH  memory read data.
- inport_in  in  WIDTH  input port value.
- csign_in  in  WIDTH  sign-extended immediate.
- bus_out  out  WIDTH  current bus value (combinational).
- pc_q, ir_q, mar_q  out  WIDTH each  register contents.
- alu_busy  out  1  multi-cycle op in progress.
- alu_done  out  1  one-cycle pulse when MUL/DIV result is written to Z.
- sel_err  out  1  registered flag: >1 select bit active in the previous cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset: every register, Z, Y, MAR, IR, PC and MDR = 0; alu_busy = 0, alu_done = 0, sel_err = 0. Reset overrides all enables, including mid-MUL/DIV: the op aborts and Z stays 0.
- Bus: combinational. Priority is lowest reg_out index first, then src_out bit0..bit7. No select active → bus = 0.
- sel_err: registered each cycle = popcount({reg_out, src_out}) > 1. Sticky until reset.
- Register writes: on posedge when the enable is high, load the bus. Writes in the same cycle as the bus read use the pre-edge value (read-modify-write in one cycle is legal).
- MDR: loads mdata_in if md_read = 1, else the bus.
- Single-cycle ALU ops (result into Z on posedge with ctl_in[5]; ZHI = 0):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(B), 10 NOT(B).
  - Shift/rotate amount = B[log2(WIDTH)-1:0].
  - Arithmetic wraps mod 2^WIDTH.
  - 13–15 reserved: Z = 0.
- Multi-cycle ALU ops (11 MUL, 12 DIV), FSM IDLE → RUN → DONE → IDLE:
  - IDLE: ctl_in[5] with op 11/12 captures Y and bus, then → RUN. alu_busy = 1 from the next cycle.
  - RUN: exactly WIDTH iterations, then → DONE.
    - MUL: signed shift-add (Booth radix-2 acceptable).
    - DIV: signed restoring, truncating toward zero.
  - DONE: Z written and alu_done = 1 for one cycle; alu_busy drops that same cycle. Next cycle → IDLE.
  - Total latency: operand capture edge + WIDTH + 1 edges to Z valid.
  - MUL: {ZHI,ZLO} = signed 2×WIDTH product.
  - DIV: ZLO = quotient; ZHI = remainder, with sign of dividend.
  - DIV by zero: same latency; ZLO = all-ones, ZHI = dividend.
- Busy rules:
  - ctl_in[5] while busy is ignored. Z is not overwritten and no new op starts.
  - Y/bus changes while busy do not affect the result.
  - Other register transfers proceed normally during busy.

Optional Feature:
- R0_ZERO_EN.
- Defined: R0 reads as 0 whenever selected, and writes to R0 are discarded (the flop is removed).
- Undefined: R0 is an ordinary register.

Test Plan:
- Reset then drive reg_out = 0, src_out = 0 → bus_out = 0, pc_q = 0, alu_busy = 0, sel_err = 0.
- mdata_in = 0x0000_0012, md_read = 1, MDR load → MDR out to R2. Then R2 out, Y in; R2 out, ADD, Z in → ZLO = 0x24, ZHI = 0.
- Y = 0xFFFF_FFFA (-6), bus = 7, MUL → alu_busy high 32 cycles; on alu_done, {ZHI,ZLO} = 0xFFFF_FFFF_FFFF_FFD6 (-42).
- Y = -17, bus = 5, DIV → ZLO = 0xFFFF_FFFD (-3), ZHI = 0xFFFF_FFFE (-2). Repeat with bus = 0 → ZLO = 0xFFFF_FFFF, ZHI = -17.
- reg_out[1] and src_out[4] high together → bus = R1 value; sel_err = 1 next cycle, held until reset.
- Start MUL, assert reset at iteration 10 → next cycle alu_busy = 0, Z = 0, no alu_done pulse.
